conv_bias_streamer: RTL
=======================

# conv_bias_streamer

Transmit side of the serial convolution-bias load stream. On a `start` pulse it reads NUM_WORDS bias words from a synchronous-read parameter memory and sends them in order, one word per handshake, to the bias buffer's serial input. The buffer stores these words and later presents them in parallel. The streamer sits between the parameter ROM/SRAM and the bias buffer. It also produces the sticky completion flag that sequences the next parameter load.

## Interface
Parameters:
- DATA_W, 16, width of one bias word
- NUM_WORDS, 32, number of words per load
- ADDR_W, 5, memory address width; must satisfy 2^ADDR_W ≥ BASE_ADDR+NUM_WORDS
- BASE_ADDR, 0, memory address of word 0

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous reset, active-high (asserted = 1)
- start  in  1  one-cycle load request; sampled only in IDLE
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory read address
- mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after `mem_rd_en`
- tx_data  out  DATA_W  current stream word
- tx_valid  out  1  `tx_data` is valid
- tx_ready  in  1  sink accepts the word; a transfer occurs when `tx_valid & tx_ready`
- tx_last  out  1  high with the final word (index NUM_WORDS-1)
- busy  out  1  high from the cycle after `start` is accepted until `done_conv_bias_tx` rises
- done_conv_bias_tx  out  1  sticky: the full load has been transferred

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN when `start`=1. This transition clears the read counter `rd_idx`, the send counter `tx_idx`, the output FIFO, the in-flight flag and `done_conv_bias_tx`.
- In DONE, `start`=1 returns to RUN with the same clears. Otherwise the FSM holds DONE.
- `start` during RUN is ignored.
- Read issue in RUN:
  - `mem_rd_en`=1 only while `rd_idx` < NUM_WORDS, and only if (fifo_count + inflight) < 2, or that sum is 2 and a transfer occurs this cycle.
  - `mem_addr` = BASE_ADDR + `rd_idx`. `rd_idx` increments on each issue.
- Returned data is pushed into a 2-entry FIFO on the cycle it arrives. The issue rule guarantees the FIFO never overflows, and that rule is asserted in verification.
- `tx_valid` = FIFO not empty. `tx_data` = FIFO head, held stable while `tx_valid` is high and `tx_ready` is low.
- `tx_last` = `tx_valid` & (`tx_idx` == NUM_WORDS-1). `tx_idx` increments on each transfer.
- A transfer with `tx_last`=1 moves the FSM to DONE. `done_conv_bias_tx` is registered and goes high the next cycle.
- Words are sent strictly in address order, with no duplicates and no drops.
- Address arithmetic is unsigned ADDR_W-bit. No wrap occurs if the parameter constraint holds.

## Timing
- Reset values: `mem_rd_en`=0, `mem_addr`=BASE_ADDR, `tx_data`=0, `tx_valid`=0, `tx_last`=0, `busy`=0, `done_conv_bias_tx`=0; state IDLE.
- Reset asserted mid-load aborts immediately. No partial `done` is produced. After release the block waits for a new `start`.
- Let `start` be sampled at edge E0:
  - `mem_rd_en` is high for address BASE_ADDR in the cycle after E0.
  - Word 0 appears with `tx_valid` one cycle after its data returns, i.e. 2 cycles after E0.
- With `tx_ready` held at 1, a new word transfers every cycle.
  - The last word transfers NUM_WORDS-1 cycles after the first.
  - `done_conv_bias_tx` rises the cycle after the last transfer and `busy` falls in the same cycle.
- Backpressure: when `tx_ready` is low, at most 2 words are buffered or in flight, and reads stall.
  - Throughput resumes at 1 word/cycle on the first cycle `tx_ready` returns high. No bubble is inserted.
- `start` in the same cycle as the final transfer is ignored, because the FSM is still in RUN.

## Test plan
- Reset, then `start` with `tx_ready`=1 and memory word[i] = 16'h1000+i → 32 words 16'h1000..16'h101F on consecutive cycles; first `tx_valid` 2 cycles after the `start` edge; `tx_last` only with 16'h101F; `done_conv_bias_tx` high the next cycle.
- `tx_ready` toggling (0 for 3 cycles, then alternating) → same ordered 32 words; `tx_data` stable during stalls; never more than 2 reads outstanding beyond accepted words; no FIFO overflow.
- `start` pulses during RUN at word 5 and word 20 → ignored: exactly 32 transfers, no address restart.
- Reset asserted at word 10 → all outputs return to reset values at once; new `start` → full 32-word load from BASE_ADDR.
- After DONE, a second `start` → `done_conv_bias_tx` clears the next cycle and a second identical 32-word sequence is sent.
- BASE_ADDR=8, ADDR_W=6 → reads addresses 8..39 in order; `tx_last` on the word from address 39.

Source files
------------

// File: rtl/conv_bias_streamer.sv
// conv_bias_streamer: reads NUM_WORDS bias words from a synchronous-read
// parameter memory and streams them in address order over a valid/ready
// link to the bias buffer, then raises a sticky completion flag.
// Reads are throttled so that buffered + in-flight words never exceed the
// 2-entry output FIFO, which lets the stream run at one word per cycle
// without bubbles and without overflow under backpressure.
module conv_bias_streamer #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned NUM_WORDS = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,          // asynchronous, active-high despite the name
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              busy,
  output logic              done_conv_bias_tx
);

  localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_rd_idx;
  logic [CNT_W-1:0]    r_tx_idx;
  logic                r_inflight;
  logic [DATA_W-1:0]   r_fifo [2];
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_count;
  logic                r_busy;
  logic                r_done;

  logic                w_load;
  logic                w_issue;
  logic                w_push;
  logic                w_xfer;
  logic                w_last;
  logic [1:0]          w_occ;

  // Stream-side handshake decode
  assign tx_valid = (r_count != 2'd0);
  assign tx_data  = r_fifo[r_rd_ptr];
  assign w_last   = tx_valid && (r_tx_idx == CNT_W'(NUM_WORDS - 1));
  assign tx_last  = w_last;
  assign w_xfer   = tx_valid && tx_ready;

  // Read data returns one cycle after the strobe
  assign w_push   = r_inflight;
  assign w_occ    = r_count + 2'(r_inflight);

  assign mem_rd_en         = w_issue;
  assign mem_addr          = ADDR_W'(BASE_ADDR) + ADDR_W'(r_rd_idx);
  assign busy              = r_busy;
  assign done_conv_bias_tx = r_done;

  // Next-state and read-issue decision
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_load      = 1'b1;
        end
      end
      S_RUN: begin
        // a slot is free now, or one frees up through this cycle's transfer
        if ((r_rd_idx < CNT_W'(NUM_WORDS)) &&
            ((w_occ < 2'd2) || ((w_occ == 2'd2) && w_xfer))) begin
          w_issue = 1'b1;
        end
        if (w_xfer && w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_load      = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Read and send counters plus in-flight tracking
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_rd_idx   <= '0;
      r_tx_idx   <= '0;
      r_inflight <= 1'b0;
    end else if (w_load) begin
      r_rd_idx   <= '0;
      r_tx_idx   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_rd_idx <= r_rd_idx + CNT_W'(1);
      end
      if (w_xfer) begin
        r_tx_idx <= r_tx_idx + CNT_W'(1);
      end
    end
  end

  // Two-entry output FIFO
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_count   <= 2'd0;
    end else if (w_load) begin
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= mem_rd_data;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_xfer) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_xfer})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Busy and sticky completion flags
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (w_load) begin
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if ((r_state == S_RUN) && w_xfer && w_last) begin
      r_busy <= 1'b0;
      r_done <= 1'b1;
    end
  end

endmodule
